// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared types for the junction phase scheduler: lamp codes, phase and state
// encodings, and the phase-to-green-head mapping.
// Optional build macro: TRAFFIC_FLASH_EN adds the FLASH state.
package traffic_pkg;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
`ifdef TRAFFIC_FLASH_EN
    localparam logic [2:0] LAMP_OFF = 3'b000;
`endif

    typedef enum logic [1:0] {
        MAIN = 2'd0,
        TURN = 2'd1,
        SIDE = 2'd2
    } phase_e;

`ifdef TRAFFIC_FLASH_EN
    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        ALLRED = 2'd2,
        FLASH  = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        ALLRED = 2'd2
    } state_e;
`endif

    // Head mask bit order: 0 = M1, 1 = M2, 2 = MT, 3 = S.
    function automatic logic [3:0] phase_heads(input phase_e p);
        case (p)
            MAIN:    return 4'b0011;
            TURN:    return 4'b0101;
            SIDE:    return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// Detector/lamp bundle between the phase scheduler and its environment.
// Optional build macro: TRAFFIC_FLASH_EN adds the flash_req input.
interface traffic_phase_scheduler_if;
    logic       tick;
    logic [2:0] req;
`ifdef TRAFFIC_FLASH_EN
    logic       flash_req;
`endif
    logic [2:0] light_M1;
    logic [2:0] light_M2;
    logic [2:0] light_MT;
    logic [2:0] light_S;
    logic [1:0] phase;
    logic       phase_start;

`ifdef TRAFFIC_FLASH_EN
    modport master (output tick, req, flash_req,
                    input  light_M1, light_M2, light_MT, light_S, phase, phase_start);
    modport slave  (input  tick, req, flash_req,
                    output light_M1, light_M2, light_MT, light_S, phase, phase_start);
`else
    modport master (output tick, req,
                    input  light_M1, light_M2, light_MT, light_S, phase, phase_start);
    modport slave  (input  tick, req,
                    output light_M1, light_M2, light_MT, light_S, phase, phase_start);
`endif
endinterface

// File: rtl/traffic_phase_scheduler_rr_pick.sv
// Round-robin selector: first pending phase after the current one in the
// cyclic order MAIN -> TURN -> SIDE -> MAIN (current phase checked last).
module traffic_rr_pick
    import traffic_pkg::*;
(
    input  logic [2:0] pending_i,
    input  phase_e     phase_i,
    output phase_e     next_o,
    output logic       valid_o
);

    logic [1:0] idx;

    // Walk offsets from farthest to nearest so the nearest pending phase wins.
    always_comb begin
        next_o  = phase_i;
        valid_o = 1'b0;
        idx     = 2'd0;
        for (int k = 3; k >= 1; k--) begin
            idx = 2'((int'(phase_i) + k) % 3);
            if (pending_i[idx]) begin
                next_o  = phase_e'(idx);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated phase scheduler for the 3-way junction. Latches detector
// calls, grants green round-robin within min/max green, and inserts yellow
// and all-red clearance between phases.
// Optional build macro: TRAFFIC_FLASH_EN adds flash_req and a FLASH state.
//
// state  | meaning
// GREEN  | phase_q has right of way; cnt_q counts green ticks
// YELLOW | heads leaving service show yellow
// ALLRED | clearance; only heads shared by phase_q and nxt_q stay green
// FLASH  | (TRAFFIC_FLASH_EN) main heads blink yellow, others blink red
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN = 5,
    parameter int MAX_GREEN = 15,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    traffic_phase_scheduler_if.slave  bus
);

    localparam int            CW      = $clog2(MAX_GREEN + 1);
    localparam logic [CW-1:0] CNT_SAT = CW'(MAX_GREEN - 1);
    localparam logic [CW-1:0] YEL_END = CW'(YELLOW_T - 1);
    localparam logic [CW-1:0] AR_END  = CW'(ALLRED_T - 1);

    state_e        state_q;
    phase_e        phase_q;
    phase_e        nxt_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    pending_q;
    logic          phase_start_q;
`ifdef TRAFFIC_FLASH_EN
    logic          to_flash_q;  // clearance in progress ends in FLASH
    logic          dark_q;      // clearance carries no head over into the next interval
    logic          toggle_q;
`endif

    logic [2:0] in_green;
    logic [2:0] pending_set;
    logic [2:0] other;
    phase_e     pick_phase;
    logic       pick_valid;
    logic       green_done;
    logic [3:0] heads_cur;
    logic [3:0] heads_nxt;
    logic [2:0] lamp [4];

    // The phase currently holding green does not re-latch its own call.
    always_comb begin
        in_green    = (state_q == GREEN) ? (3'b001 << phase_q) : 3'b000;
        pending_set = pending_q | (bus.req & ~in_green);
        other       = pending_q & ~(3'b001 << phase_q);
        green_done  = (int'(cnt_q) + 1 >= MAX_GREEN) ||
                      ((int'(cnt_q) + 1 >= MIN_GREEN) && !bus.req[phase_q]);
    end

    traffic_rr_pick u_pick (
        .pending_i (other),
        .phase_i   (phase_q),
        .next_o    (pick_phase),
        .valid_o   (pick_valid)
    );

    // Phase sequencing, call latching and interval timing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= GREEN;
            phase_q       <= MAIN;
            nxt_q         <= MAIN;
            cnt_q         <= '0;
            pending_q     <= '0;
            phase_start_q <= 1'b0;
`ifdef TRAFFIC_FLASH_EN
            to_flash_q    <= 1'b0;
            dark_q        <= 1'b0;
            toggle_q      <= 1'b0;
`endif
        end else begin
            phase_start_q <= 1'b0;
            pending_q     <= pending_set;
            if (bus.tick) begin
                case (state_q)
                    GREEN: begin
`ifdef TRAFFIC_FLASH_EN
                        if (bus.flash_req) begin
                            state_q    <= YELLOW;
                            cnt_q      <= '0;
                            to_flash_q <= 1'b1;
                            dark_q     <= 1'b1;
                        end else
`endif
                        if (!pick_valid) begin
                            if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 1'b1;
                        end else if (green_done) begin
                            state_q <= YELLOW;
                            cnt_q   <= '0;
                            nxt_q   <= pick_phase;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    YELLOW: begin
`ifdef TRAFFIC_FLASH_EN
                        if (bus.flash_req) to_flash_q <= 1'b1;
`endif
                        if (cnt_q == YEL_END) begin
                            state_q <= ALLRED;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ALLRED: begin
                        if (cnt_q == AR_END) begin
                            cnt_q <= '0;
`ifdef TRAFFIC_FLASH_EN
                            if (to_flash_q || bus.flash_req) begin
                                state_q    <= FLASH;
                                to_flash_q <= 1'b0;
                                toggle_q   <= 1'b0;
                            end else begin
                                state_q       <= GREEN;
                                phase_q       <= nxt_q;
                                phase_start_q <= 1'b1;
                                pending_q     <= pending_set & ~(3'b001 << nxt_q);
                                dark_q        <= 1'b0;
                            end
`else
                            state_q       <= GREEN;
                            phase_q       <= nxt_q;
                            phase_start_q <= 1'b1;
                            pending_q     <= pending_set & ~(3'b001 << nxt_q);
`endif
                        end else begin
`ifdef TRAFFIC_FLASH_EN
                            if (bus.flash_req) to_flash_q <= 1'b1;
`endif
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
`ifdef TRAFFIC_FLASH_EN
                    FLASH: begin
                        if (bus.flash_req) begin
                            toggle_q <= ~toggle_q;
                        end else begin
                            state_q <= ALLRED;
                            cnt_q   <= '0;
                            nxt_q   <= MAIN;
                        end
                    end
`endif
                    default: begin
                        state_q <= GREEN;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    // Lamp heads decoded directly from the registered state, no extra latency.
    always_comb begin
        heads_cur = phase_heads(phase_q);
`ifdef TRAFFIC_FLASH_EN
        heads_nxt = dark_q ? 4'b0000 : phase_heads(nxt_q);
`else
        heads_nxt = phase_heads(nxt_q);
`endif
        for (int h = 0; h < 4; h++) begin
            lamp[h] = LAMP_RED;
            case (state_q)
                GREEN:  lamp[h] = heads_cur[h] ? LAMP_GRN : LAMP_RED;
                YELLOW: lamp[h] = (heads_cur[h] && heads_nxt[h]) ? LAMP_GRN :
                                  heads_cur[h] ? LAMP_YEL : LAMP_RED;
                ALLRED: lamp[h] = (heads_cur[h] && heads_nxt[h]) ? LAMP_GRN : LAMP_RED;
`ifdef TRAFFIC_FLASH_EN
                FLASH:  lamp[h] = toggle_q ? LAMP_OFF : ((h < 2) ? LAMP_YEL : LAMP_RED);
`endif
                default: lamp[h] = LAMP_RED;
            endcase
        end
    end

    assign bus.light_M1    = lamp[0];
    assign bus.light_M2    = lamp[1];
    assign bus.light_MT    = lamp[2];
    assign bus.light_S     = lamp[3];
    assign bus.phase       = phase_q;
    assign bus.phase_start = phase_start_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler (default build, flash feature off).
// A tick-level reference model predicts the lamp/phase outputs for every
// clock; predictions are queued by the driver and checked by a monitor.
module tb_traffic_phase_scheduler;

    localparam int MIN_G = 5;
    localparam int MAX_G = 15;
    localparam int YEL   = 2;
    localparam int AR    = 1;

    typedef struct packed {
        logic [2:0] m1;
        logic [2:0] m2;
        logic [2:0] mt;
        logic [2:0] s;
        logic [1:0] ph;
        logic       ps;
    } obs_t;

    localparam obs_t RST_OBS = {3'b001, 3'b001, 3'b100, 3'b100, 2'd0, 1'b0};

    logic clk = 1'b0;
    logic rst;

    traffic_phase_scheduler_if bus();

    traffic_phase_scheduler #(
        .MIN_GREEN (MIN_G),
        .MAX_GREEN (MAX_G),
        .YELLOW_T  (YEL),
        .ALLRED_T  (AR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    obs_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: interval kind (0 green, 1 yellow, 2 all-red),
    // ticks elapsed in the interval, served phase, chosen next phase, calls.
    int     m_state;
    int     m_ph;
    int     m_nx;
    int     m_el;
    bit [2:0] m_calls;
    bit     m_ps;

    function automatic bit [3:0] heads(input int p);
        case (p)
            0:       return 4'b0011;
            1:       return 4'b0101;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic bit has(input bit [2:0] v, input int i);
        return ((v >> i) & 3'b001) != 3'b000;
    endfunction

    function void model_reset();
        m_state = 0; m_ph = 0; m_nx = 0; m_el = 0; m_calls = 3'b000; m_ps = 1'b0;
    endfunction

    function void model_step(input bit t, input bit [2:0] r);
        bit [2:0] nc;
        bit [2:0] others;
        nc = m_calls;
        for (int i = 0; i < 3; i++)
            if (has(r, i) && !(m_state == 0 && m_ph == i)) nc = nc | (3'b001 << i);
        m_ps = 1'b0;
        if (t) begin
            m_el = m_el + 1;
            if (m_state == 0) begin
                others = m_calls & ~(3'b001 << m_ph);
                if (others != 3'b000 && (m_el >= MAX_G || (m_el >= MIN_G && !has(r, m_ph)))) begin
                    m_state = 1;
                    m_el    = 0;
                    m_nx    = has(others, (m_ph + 1) % 3) ? (m_ph + 1) % 3 : (m_ph + 2) % 3;
                end
            end else if (m_state == 1) begin
                if (m_el == YEL) begin m_state = 2; m_el = 0; end
            end else begin
                if (m_el == AR) begin
                    m_state = 0; m_el = 0; m_ph = m_nx; m_ps = 1'b1;
                    nc = nc & ~(3'b001 << m_ph);
                end
            end
        end
        m_calls = nc;
    endfunction

    function obs_t model_out();
        obs_t o;
        bit [3:0] g;
        bit [3:0] n;
        logic [2:0] l [4];
        g = heads(m_ph);
        n = heads(m_nx);
        for (int h = 0; h < 4; h++) begin
            if (m_state == 0)      l[h] = g[h] ? 3'b001 : 3'b100;
            else if (m_state == 1) l[h] = (g[h] && n[h]) ? 3'b001 : (g[h] ? 3'b010 : 3'b100);
            else                   l[h] = (g[h] && n[h]) ? 3'b001 : 3'b100;
        end
        o.m1 = l[0]; o.m2 = l[1]; o.mt = l[2]; o.s = l[3];
        o.ph = 2'(m_ph);
        o.ps = m_ps;
        return o;
    endfunction

    function obs_t observe();
        obs_t a;
        a.m1 = bus.light_M1; a.m2 = bus.light_M2; a.mt = bus.light_MT; a.s = bus.light_S;
        a.ph = bus.phase;    a.ps = bus.phase_start;
        return a;
    endfunction

    task check_direct(input string name);
        obs_t a;
        a = observe();
        total++;
        if (a !== RST_OBS) begin
            bad++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, a, RST_OBS);
        end
    endtask

    // One clock of stimulus; the prediction for the following edge is queued.
    task cyc(input bit t, input bit [2:0] r, input bit rs);
        @(negedge clk);
        if (rs && !rst) begin
            rst = 1'b1;
            #1;
            check_direct("async_rst");
        end else begin
            rst = rs;
        end
        bus.tick = t;
        bus.req  = r;
        if (rs) model_reset();
        else    model_step(t, r);
        exp_q.push_back(model_out());
    endtask

    // Monitor: compare every registered update against the queued prediction.
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = observe();
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL cyc t=%0t got=%h expected=%h", $time, a, e);
                end
            end
        end
    end

    initial begin
        bit [2:0] r;
        bit       t;
        bit       rs;
        rst      = 1'b1;
        bus.tick = 1'b0;
        bus.req  = 3'b000;
        model_reset();
        #1;
        check_direct("reset");

        // ticks while reset is held must be ignored
        for (int i = 0; i < 4; i++) cyc(1'b1, 3'b000, 1'b1);

        // idle: MAIN rests green, no phase_start
        for (int i = 0; i < 80; i++) cyc(i[0], 3'b000, 1'b0);

        // side call from a fresh MAIN green: gap-out at MIN_GREEN
        cyc(1'b1, 3'b000, 1'b1);
        cyc(1'b1, 3'b100, 1'b0);
        for (int i = 0; i < 60; i++) cyc(i[0], 3'b000, 1'b0);

        // back to MAIN, then hold MAIN detector with a turn call: max-out
        cyc(1'b0, 3'b001, 1'b0);
        for (int i = 0; i < 40; i++) cyc(i[0], 3'b000, 1'b0);
        cyc(1'b0, 3'b011, 1'b0);
        for (int i = 0; i < 80; i++) cyc(i[0], 3'b001, 1'b0);

        // turn and side calls together: MAIN -> TURN -> SIDE
        for (int i = 0; i < 80; i++) cyc(i[0], 3'b000, 1'b0);
        cyc(1'b0, 3'b001, 1'b0);
        for (int i = 0; i < 60; i++) cyc(i[0], 3'b000, 1'b0);
        cyc(1'b0, 3'b110, 1'b0);
        for (int i = 0; i < 80; i++) cyc(i[0], 3'b000, 1'b0);

        // reset in the middle of yellow, with a call still latched
        cyc(1'b0, 3'b101, 1'b0);
        for (int i = 0; i < 60 && m_state != 1; i++) cyc(1'b1, 3'b000, 1'b0);
        cyc(1'b0, 3'b000, 1'b0);
        cyc(1'b1, 3'b000, 1'b1);
        cyc(1'b1, 3'b000, 1'b1);
        for (int i = 0; i < 60; i++) cyc(i[0], 3'b000, 1'b0);

        // randomized traffic, tick spacing and occasional resets
        r = 3'b000;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) r = 3'($urandom_range(0, 7));
            t  = 1'($urandom_range(0, 1));
            rs = ($urandom_range(0, 499) == 0);
            cyc(t, r, rs);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
- Demand-actuated phase scheduler for the 3-way junction: main-through (M1, M2), main turn (MT) and side road (S).
- Replaces the fixed-time cycle with detector-driven arbitration.
- Latches vehicle calls per phase and grants green round-robin, bounded by min/max green. Inserts yellow and all-red clearance between phases.
- Drives the four 3-bit lamp heads. Encoding: 001 green, 010 yellow, 100 red.

Parameters:
- MIN_GREEN, 5: minimum green length in ticks; range 1..MAX_GREEN.
- MAX_GREEN, 15: maximum green length in ticks while another call is pending.
- YELLOW_T, 2: yellow length in ticks; >=1.
- ALLRED_T, 1: all-red clearance length in ticks; >=1.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset; asynchronous, active-high.
- tick, input, 1: one-cycle timebase pulse (1 s strobe); all timers advance only when tick=1.
- req, input, 3: detector levels. Bit 0 = MAIN, bit 1 = TURN, bit 2 = SIDE.
- light_M1, light_M2, light_MT, light_S, output, 3 each: lamp heads.
- phase, output, 2: current/last green phase. 0 = MAIN, 1 = TURN, 2 = SIDE; 3 is never driven.
- phase_start, output, 1: one-cycle pulse on the cycle a GREEN interval begins.

Behaviour:

Reset:
- state = GREEN, phase = MAIN, nxt = MAIN, cnt = 0, pending = 000, phase_start = 0.
- Lamps: M1 = M2 = 001, MT = S = 100.

State machine GREEN -> YELLOW -> ALLRED -> GREEN:
- cnt is cleared on every state entry.
- cnt width is $clog2(MAX_GREEN+1).
- A timed state lasting T ticks exits on the tick where cnt == T-1; otherwise cnt increments on each tick.

Call latching:
- pending[i] is set when req[i] = 1, unless phase i is currently in GREEN.
- pending[phase] is cleared in the cycle GREEN for that phase is entered. The clear wins over a same-cycle set.

GREEN, evaluated on tick:
- other = pending with the bit for phase masked off.
- If other == 0: stay in GREEN; cnt saturates at MAX_GREEN-1. MAIN rests in green indefinitely with no calls.
- If other != 0: go to YELLOW when cnt+1 >= MAX_GREEN, or when (cnt+1 >= MIN_GREEN and req[phase] == 0) (gap-out).
- Otherwise extend green.
- On the GREEN->YELLOW edge, latch nxt = the first pending bit after phase in cyclic order MAIN -> TURN -> SIDE -> MAIN.

YELLOW:
- Lasts YELLOW_T ticks, then go to ALLRED.

ALLRED:
- Lasts ALLRED_T ticks, then go to GREEN with phase = nxt and phase_start = 1 for one cycle.

Lamp decode (combinational from state, phase and nxt; no added latency):
- GREEN heads per phase:
  - MAIN: M1, M2 green.
  - TURN: M1, MT green.
  - SIDE: S green.
- All other heads are red in GREEN.
- YELLOW: heads green in phase and also green in nxt stay 001. Heads green only in phase show 010. All others show 100.
- ALLRED: heads green in both phase and nxt stay 001; all others show 100. Example: M1 stays green continuously on MAIN->TURN.

Boundary conditions:
- A call that drops during YELLOW or ALLRED is still served; the pending bit was latched.
- Ticks arriving on consecutive cycles are legal.
- tick while rst is asserted is ignored.
- Reset mid-clearance returns immediately to MAIN green.

Optional Feature:
- Macro: TRAFFIC_FLASH_EN.

With the macro defined:
- Adds input flash_req (1 bit) and state FLASH.
- flash_req is sampled on tick.
- From GREEN, the block takes YELLOW then ALLRED as normal, then enters FLASH. A flash_req seen in YELLOW or ALLRED completes the clearance, then enters FLASH.
- In FLASH, a toggle bit flips every tick:
  - M1 and M2 alternate 010 / 000.
  - MT and S alternate 100 / 000.
- Pending calls keep latching during FLASH.
- On flash_req deassert (sampled on tick): ALLRED for ALLRED_T ticks, then MAIN green with phase_start = 1.

Without the macro:
- No port, no FLASH state, no toggle register.

Decomposition:
- Package traffic_pkg holds:
  - Lamp codes LAMP_RED = 3'b100, LAMP_YEL = 3'b010, LAMP_GRN = 3'b001.
  - Phase enum MAIN / TURN / SIDE (2-bit).
  - State enum GREEN / YELLOW / ALLRED / FLASH.
  - Function phase_heads(phase) returning the 4-bit green-head mask.
- Sub-module traffic_rr_pick: combinational round-robin selector (pending[2:0], current phase -> next phase, valid).

Test Plan:
1. No req, 40 ticks -> lamps stay M1 = M2 = 001, MT = S = 100; phase = 0; phase_start never pulses.
2. req[2] pulsed at tick 0, req[0] = 0 -> yellow (M1 = M2 = 010) begins after tick 4 (MIN_GREEN = 5). Then 2 ticks yellow, 1 tick all red (all 100), then S = 001, phase = 2, phase_start pulses once.
3. req[0] held high, req[1] pulsed -> MAIN extends to MAX_GREEN: yellow starts after 15 ticks, with M1 held 001 and only M2 at 010. TURN green: M1 = MT = 001.
4. req[1] and req[2] both pulsed during MAIN green -> order MAIN -> TURN -> SIDE -> rest in SIDE. Both pending bits clear at their green starts.
5. rst asserted mid-YELLOW, asynchronous -> lamps return to the MAIN pattern in the same cycle; pending = 000.
6. TRAFFIC_FLASH_EN defined: flash_req = 1 during SIDE green -> S = 010 for 2 ticks, all red for 1 tick, then M1 toggles 010/000 per tick. Deassert -> 1 tick all red, then MAIN green.
